// File: rtl/dm_pkg.sv
// Shared constants for the data memory: default geometry and write-enable encodings.
package dm_pkg;

  localparam int unsigned DM_ADDR_WIDTH = 32;
  localparam int unsigned DM_DATA_WIDTH = 32;
  localparam int unsigned DM_DEPTH_LOG2 = 10;

  localparam logic DM_WRITE_ENABLED  = 1'b1;
  localparam logic DM_WRITE_DISABLED = 1'b0;

endpackage

// File: rtl/dm_addr_decode.sv
// Byte address to word index: drops the byte offset and any bits above the array depth.
module dm_addr_decode #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DEPTH_LOG2-1:0] word_idx
);

  // Offset and high bits are discarded on purpose: misaligned truncates, out-of-range wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:DEPTH_LOG2+2], addr[1:0]};

  assign word_idx = addr[DEPTH_LOG2+1:2];

endmodule

// File: rtl/dm.sv
// Word-organised data memory: one combinational read port, one clocked write port,
// whole array cleared asynchronously by rst_n.
module dm
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DM_DATA_WIDTH,
  parameter int unsigned DEPTH_LOG2 = DM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] read_result
);

  localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;

  dm_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rd_decode (
    .addr     (read_addr),
    .word_idx (rd_idx)
  );

  dm_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_wr_decode (
    .addr     (write_addr),
    .word_idx (wr_idx)
  );

  // An unknown enable compares false, so it never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_enable == DM_WRITE_ENABLED) begin
      mem_q[wr_idx] <= write_data;
    end
  end

  // No bypass: a same-word write shows up only after the edge commits it.
  assign read_result = rst_n ? mem_q[rd_idx] : '0;

endmodule

// File: tb/tb_dm.sv
// Directed bench for dm: reset clearing, write/read ports, write-disable, same-word
// read-during-write, alignment truncation and address wrap.
module tb_dm;
  import dm_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] read_addr;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_result;

  int n_pass;
  int n_total;

  dm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_addr    (read_addr),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_result  (read_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] expected);
    n_total++;
    assert (read_result === expected) n_pass++;
    else $error("FAIL %s: read_result=%h expected=%h", tag, read_result, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [31:0] addr, input string tag, input logic [31:0] expected);
    read_addr = addr;
    #1;
    check(tag, expected);
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst_n        = 1'b0;
    read_addr    = '0;
    write_addr   = '0;
    write_data   = '0;
    write_enable = DM_WRITE_DISABLED;

    #2;
    read_chk(32'd0, "reset_addr0", 32'h0);
    read_chk(32'd4, "reset_addr4", 32'h0);

    // Write attempted while held in reset must be dropped.
    write_addr   = 32'd4;
    write_data   = 32'hffffffff;
    write_enable = DM_WRITE_ENABLED;
    tick();
    write_enable = DM_WRITE_DISABLED;
    #2;
    rst_n = 1'b1;
    read_chk(32'd4, "write_in_reset_ignored", 32'h0);

    // Write word 1 while reading word 0.
    tick();
    write_addr   = 32'd4;
    write_data   = 32'h01234567;
    write_enable = DM_WRITE_ENABLED;
    read_chk(32'd0, "w1_read0_before", 32'h0);
    tick();
    write_enable = DM_WRITE_DISABLED;
    read_chk(32'd4, "w1_addr4_after", 32'h01234567);
    read_chk(32'd0, "w1_addr0_after", 32'h0);

    // Write word 0 while reading word 1.
    write_addr   = 32'd0;
    write_data   = 32'h89abcdef;
    write_enable = DM_WRITE_ENABLED;
    read_chk(32'd4, "w0_read4_comb", 32'h01234567);
    tick();
    write_enable = DM_WRITE_DISABLED;
    read_chk(32'd0, "w0_addr0_after", 32'h89abcdef);

    // Disabled writes over several edges.
    write_addr = 32'd4;
    write_data = 32'hdeedbeef;
    tick();
    tick();
    tick();
    read_chk(32'd0, "we0_addr0_held", 32'h89abcdef);
    read_chk(32'd4, "we0_addr4_held", 32'h01234567);

    // Same-word read during write: old value before the edge, new after.
    write_addr   = 32'd8;
    write_data   = 32'hcafef00d;
    write_enable = DM_WRITE_ENABLED;
    read_chk(32'd8, "rdw_before_edge", 32'h0);
    tick();
    write_enable = DM_WRITE_DISABLED;
    read_chk(32'd8, "rdw_after_edge", 32'hcafef00d);

    // Misaligned write address truncates to the containing word.
    write_addr   = 32'd6;
    write_data   = 32'h11112222;
    write_enable = DM_WRITE_ENABLED;
    tick();
    write_enable = DM_WRITE_DISABLED;
    read_chk(32'd4, "misaligned_wr_at4", 32'h11112222);
    read_chk(32'd7, "misaligned_rd_at7", 32'h11112222);

    // Out-of-range write address wraps modulo depth.
    write_addr   = 32'd4096 + 32'd12;
    write_data   = 32'h33334444;
    write_enable = DM_WRITE_ENABLED;
    tick();
    write_enable = DM_WRITE_DISABLED;
    read_chk(32'd12, "wrap_wr_at12", 32'h33334444);
    read_chk(32'hfffff00c, "wrap_rd_high", 32'h33334444);

    // Last word of the array.
    write_addr   = 32'd4092;
    write_data   = 32'hffff0000;
    write_enable = DM_WRITE_ENABLED;
    tick();
    write_enable = DM_WRITE_DISABLED;
    read_chk(32'd4092, "last_word", 32'hffff0000);
    read_chk(32'd8, "neighbour_intact", 32'hcafef00d);

    // Reset pulse between edges must clear the array without a clock.
    rst_n = 1'b0;
    read_chk(32'd0, "reset_forces_zero", 32'h0);
    #1;
    rst_n = 1'b1;
    read_chk(32'd0, "post_reset_addr0", 32'h0);
    read_chk(32'd4, "post_reset_addr4", 32'h0);
    read_chk(32'd8, "post_reset_addr8", 32'h0);
    read_chk(32'd12, "post_reset_addr12", 32'h0);
    read_chk(32'd4092, "post_reset_last", 32'h0);

    // Write works again after mid-cycle deassertion.
    write_addr   = 32'd0;
    write_data   = 32'h00000077;
    write_enable = DM_WRITE_ENABLED;
    tick();
    write_enable = DM_WRITE_DISABLED;
    read_chk(32'd0, "write_after_reset", 32'h00000077);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
